// File: rtl/voter_plus_pkg.sv
// Shared constants for the weighted sticky voting tally.
// Group sizes, per-group weights, counter widths and the tally width.
package voter_plus_pkg;

  localparam int unsigned NP_N     = 32;
  localparam int unsigned VIP_N    = 8;

  localparam int unsigned NP_W     = 1;
  localparam int unsigned VIP_W    = 4;
  localparam int unsigned VVIP_W   = 16;

  localparam int unsigned RESULT_W = 8;

  // Popcount widths: enough bits to hold 0..N inclusive.
  localparam int unsigned NP_CW    = $clog2(NP_N + 1);
  localparam int unsigned VIP_CW   = $clog2(VIP_N + 1);

  // Weights are powers of two, so weighting is a left shift.
  localparam int unsigned VIP_SH   = $clog2(VIP_W);
  localparam int unsigned VVIP_SH  = $clog2(VVIP_W);

endpackage : voter_plus_pkg

// File: rtl/voter_plus_popcount.sv
// Parameterised population count.
// Ports:
//   i_bits  [N-1:0]            input vector
//   o_cnt_c [$clog2(N+1)-1:0]  number of set bits (combinational)
module voter_plus_popcount #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]           i_bits,
  output logic [$clog2(N+1)-1:0] o_cnt_c
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [CW-1:0] w_cnt;

  // Plain accumulate; synthesis builds the adder tree.
  always_comb begin
    w_cnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_cnt = w_cnt + CW'(i_bits[i]);
    end
  end

  assign o_cnt_c = w_cnt;

endmodule : voter_plus_popcount

// File: rtl/voter_plus.sv
// Weighted, sticky voting tally.
// Records which of 32 normal, 8 VIP and 1 VVIP voters have voted since the
// last reset and presents the weighted total combinationally.
// Ports:
//   clk     system clock, rising edge
//   reset   synchronous active-low reset, clears all has-voted flags
//   np      [31:0] normal voter strobes (weight 1)
//   vip     [7:0]  VIP voter strobes (weight 4)
//   vvip    VVIP voter strobe (weight 16)
//   result  [7:0]  weighted tally of recorded votes, driven from flags only
module voter_plus
  import voter_plus_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NP_N-1:0]     np,
  input  logic [VIP_N-1:0]    vip,
  input  logic                vvip,
  output logic [RESULT_W-1:0] result
);

  logic [NP_N-1:0]   r_np_f;
  logic [VIP_N-1:0]  r_vip_f;
  logic              r_vvip_f;

  logic [NP_CW-1:0]  w_np_cnt;
  logic [VIP_CW-1:0] w_vip_cnt;

  // Sticky has-voted flags; reset wins over votes on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_np_f   <= '0;
      r_vip_f  <= '0;
      r_vvip_f <= 1'b0;
    end else begin
      r_np_f   <= r_np_f  | np;
      r_vip_f  <= r_vip_f | vip;
      r_vvip_f <= r_vvip_f | vvip;
    end
  end

  voter_plus_popcount #(.N(NP_N)) u_np_cnt (
    .i_bits  (r_np_f),
    .o_cnt_c (w_np_cnt)
  );

  voter_plus_popcount #(.N(VIP_N)) u_vip_cnt (
    .i_bits  (r_vip_f),
    .o_cnt_c (w_vip_cnt)
  );

  // Max 32 + 32 + 16 = 80, so the 8-bit sum never overflows.
  assign result = RESULT_W'(w_np_cnt)
                + (RESULT_W'(w_vip_cnt) << VIP_SH)
                + (RESULT_W'(r_vvip_f)  << VVIP_SH);

endmodule : voter_plus

// File: tb/tb_voter_plus.sv
// Self-checking bench for voter_plus: directed literal checks plus randomized
// voting traffic compared every cycle against a set-based tally model.
module tb_voter_plus;

  logic        clk;
  logic        reset;
  logic [31:0] np;
  logic [7:0]  vip;
  logic        vvip;
  logic [7:0]  result;

  int total = 0;
  int bad   = 0;

  voter_plus dut (
    .clk    (clk),
    .reset  (reset),
    .np     (np),
    .vip    (vip),
    .vvip   (vvip),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the set of voters who have voted since reset.
  bit m_np_voted  [32];
  bit m_vip_voted [8];
  bit m_vvip_voted;
  bit m_valid = 1'b0;

  function automatic int model_tally();
    int n_np = 0;
    int n_vip = 0;
    foreach (m_np_voted[i])  if (m_np_voted[i])  n_np++;
    foreach (m_vip_voted[j]) if (m_vip_voted[j]) n_vip++;
    return n_np * 1 + n_vip * 4 + (m_vvip_voted ? 16 : 0);
  endfunction

  always @(posedge clk) begin
    if (reset === 1'b0) begin
      foreach (m_np_voted[i])  m_np_voted[i]  = 1'b0;
      foreach (m_vip_voted[j]) m_vip_voted[j] = 1'b0;
      m_vvip_voted = 1'b0;
      m_valid      = 1'b1;
    end else begin
      for (int i = 0; i < 32; i++) if (np[i])  m_np_voted[i]  = 1'b1;
      for (int j = 0; j < 8;  j++) if (vip[j]) m_vip_voted[j] = 1'b1;
      if (vvip) m_vvip_voted = 1'b1;
    end
  end

  // Compare process: every cycle once the model is defined.
  always @(negedge clk) begin
    if (m_valid) begin
      total++;
      if (int'(result) !== model_tally()) begin
        bad++;
        $display("FAIL model_cmp t=%0t result=%0d want=%0d", $time, result, model_tally());
      end
    end
  end

  // Drive one edge worth of inputs, then sample just after that edge.
  task automatic apply(input logic rst, input logic [31:0] n,
                       input logic [7:0] v, input logic vv);
    @(negedge clk);
    reset = rst;
    np    = n;
    vip   = v;
    vvip  = vv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input int want);
    total++;
    if (int'(result) !== want) begin
      bad++;
      $display("FAIL %s result=%0d want=%0d", name, result, want);
    end
  endtask

  task automatic do_reset();
    apply(1'b0, 32'h0, 8'h0, 1'b0);
    check_lit("reset_clear", 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    np    = '0;
    vip   = '0;
    vvip  = 1'b0;

    // Reset held with every voter active.
    apply(1'b0, 32'hFFFF_FFFF, 8'hFF, 1'b1);
    check_lit("reset_hold_1", 0);
    apply(1'b0, 32'hFFFF_FFFF, 8'hFF, 1'b1);
    check_lit("reset_hold_2", 0);
    apply(1'b1, 32'h0, 8'h0, 1'b0);
    check_lit("idle_after_reset", 0);

    // Weights.
    apply(1'b1, 32'h0000_0001, 8'h00, 1'b0);
    check_lit("weight_np", 1);
    apply(1'b1, 32'h0, 8'h01, 1'b0);
    check_lit("weight_vip", 5);
    apply(1'b1, 32'h0, 8'h00, 1'b1);
    check_lit("weight_vvip", 21);

    // Stickiness / no double count.
    do_reset();
    apply(1'b1, 32'h0000_000F, 8'h0, 1'b0);
    check_lit("sticky_set", 4);
    apply(1'b1, 32'h0, 8'h0, 1'b0);
    check_lit("sticky_hold", 4);
    apply(1'b1, 32'h0000_0003, 8'h0, 1'b0);
    check_lit("sticky_revote", 4);

    // Full house.
    apply(1'b1, 32'hFFFF_FFFF, 8'hFF, 1'b1);
    check_lit("full_house", 80);
    apply(1'b1, 32'hFFFF_FFFF, 8'hFF, 1'b1);
    check_lit("full_house_hold", 80);

    // Reset priority and mid-run reset.
    do_reset();
    apply(1'b1, 32'h0000_0001, 8'h01, 1'b1);
    check_lit("reach_21", 21);
    apply(1'b0, 32'h0, 8'h03, 1'b0);
    check_lit("reset_priority", 0);
    apply(1'b1, 32'h0, 8'h03, 1'b0);
    check_lit("after_reset_vip", 8);

    // Incremental mix.
    do_reset();
    apply(1'b1, 32'h8000_0001, 8'h00, 1'b0);
    check_lit("mix_np_edges", 2);
    apply(1'b1, 32'h0, 8'h80, 1'b0);
    check_lit("mix_vip_msb", 6);
    apply(1'b1, 32'h0000_0100, 8'h00, 1'b0);
    check_lit("mix_np_mid", 7);

    // Random traffic: sparse votes, occasional resets.
    for (int k = 0; k < 600; k++) begin
      logic        r_rst;
      logic [31:0] r_np;
      logic [7:0]  r_vip;
      logic        r_vv;
      r_rst = ($urandom_range(0, 39) != 0);
      r_np  = $urandom & $urandom & $urandom & $urandom;
      r_vip = 8'($urandom & $urandom & $urandom);
      r_vv  = ($urandom_range(0, 15) == 0);
      apply(r_rst, r_np, r_vip, r_vv);
    end

    apply(1'b1, 32'h0, 8'h0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_voter_plus
